// File: rtl/integer_divider.sv
// Iterative restoring divider: one quotient bit per clock, valid/ready on both sides.
// Define INTEGER_DIVIDER_SIGNED_EN for two's-complement operands (sign/magnitude around an unsigned core).
module integer_divider #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  divide_by_zero,
    output logic                  overflow
);
    localparam int DW = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] quo_q, quo_d;
    logic [DW-1:0] rem_q, rem_d;
    logic [DW-1:0] dvsr_q, dvsr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] quot_out_q, quot_out_d;
    logic [DW-1:0] rem_out_q, rem_out_d;
    logic          dbz_q, dbz_d;

    logic [DW:0]   shifted, diff;
    logic [DW-1:0] iter_quo, iter_rem, fin_quo, fin_rem;
    logic [DW-1:0] dvd_mag, dvs_mag, dbz_quo;

`ifdef INTEGER_DIVIDER_SIGNED_EN
    logic neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic ovf_pend_q, ovf_pend_d, ovf_q, ovf_d;
    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

    assign start_ready    = (state_q == IDLE);
    assign result_valid   = (state_q == DONE);
    assign quotient       = quot_out_q;
    assign remainder      = rem_out_q;
    assign divide_by_zero = dbz_q;

    always_comb begin
        // Partial remainder stays below the divisor, so DW bits hold it; the shift needs one more.
        shifted  = {rem_q, quo_q[DW-1]};
        diff     = shifted - {1'b0, dvsr_q};
        iter_rem = diff[DW] ? shifted[DW-1:0] : diff[DW-1:0];
        iter_quo = {quo_q[DW-2:0], ~diff[DW]};
`ifdef INTEGER_DIVIDER_SIGNED_EN
        dvd_mag  = dividend[DW-1] ? -dividend : dividend;
        dvs_mag  = divisor[DW-1] ? -divisor : divisor;
        dbz_quo  = dividend[DW-1] ? DW'(1) : '1;
        fin_quo  = neg_quo_q ? -iter_quo : iter_quo;
        fin_rem  = neg_rem_q ? -iter_rem : iter_rem;
`else
        dvd_mag  = dividend;
        dvs_mag  = divisor;
        dbz_quo  = '1;
        fin_quo  = iter_quo;
        fin_rem  = iter_rem;
`endif
    end

    always_comb begin
        state_d    = state_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        dvsr_d     = dvsr_q;
        cnt_d      = cnt_q;
        quot_out_d = quot_out_q;
        rem_out_d  = rem_out_q;
        dbz_d      = dbz_q;
`ifdef INTEGER_DIVIDER_SIGNED_EN
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        ovf_pend_d = ovf_pend_q;
        ovf_d      = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start_valid) begin
                    if (divisor == '0) begin
                        state_d    = DONE;
                        quot_out_d = dbz_quo;
                        rem_out_d  = dividend;
                        dbz_d      = 1'b1;
`ifdef INTEGER_DIVIDER_SIGNED_EN
                        ovf_d      = 1'b0;
`endif
                    end else begin
                        state_d = CALC;
                        quo_d   = dvd_mag;
                        dvsr_d  = dvs_mag;
                        rem_d   = '0;
                        cnt_d   = CW'(DW - 1);
`ifdef INTEGER_DIVIDER_SIGNED_EN
                        neg_quo_d  = dividend[DW-1] ^ divisor[DW-1];
                        neg_rem_d  = dividend[DW-1];
                        ovf_pend_d = (dividend == {1'b1, {(DW-1){1'b0}}}) && (divisor == '1);
`endif
                    end
                end
            end
            CALC: begin
                quo_d = iter_quo;
                rem_d = iter_rem;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d    = DONE;
                    quot_out_d = fin_quo;
                    rem_out_d  = fin_rem;
                    dbz_d      = 1'b0;
`ifdef INTEGER_DIVIDER_SIGNED_EN
                    ovf_d      = ovf_pend_q;
`endif
                end
            end
            DONE: begin
                if (result_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            quo_q      <= '0;
            rem_q      <= '0;
            dvsr_q     <= '0;
            cnt_q      <= '0;
            quot_out_q <= '0;
            rem_out_q  <= '0;
            dbz_q      <= 1'b0;
`ifdef INTEGER_DIVIDER_SIGNED_EN
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            ovf_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            dvsr_q     <= dvsr_d;
            cnt_q      <= cnt_d;
            quot_out_q <= quot_out_d;
            rem_out_q  <= rem_out_d;
            dbz_q      <= dbz_d;
`ifdef INTEGER_DIVIDER_SIGNED_EN
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            ovf_pend_q <= ovf_pend_d;
            ovf_q      <= ovf_d;
`endif
        end
    end
endmodule

// File: tb/tb_integer_divider.sv
// Directed bench for integer_divider (DATA_WIDTH=16): results, latency, backpressure, reset.
module tb_integer_divider;
    logic        clk = 1'b0;
    logic        rst_n, start_valid, start_ready, result_valid, result_ready;
    logic [15:0] dividend, divisor, quotient, remainder;
    logic        divide_by_zero, overflow;
    int          n_cmp = 0;
    int          n_err = 0;
    int          lat;

    integer_divider #(.DATA_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
        .dividend(dividend), .divisor(divisor), .result_valid(result_valid),
        .result_ready(result_ready), .quotient(quotient), .remainder(remainder),
        .divide_by_zero(divide_by_zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and count cycles until result_valid (cycle 1 = right after the accept edge).
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, output int l);
        int w = 0;
        while (!start_ready && w < 50) begin tick(); w++; end
        chk("issue_ready", start_ready, 1);
        start_valid = 1'b1; dividend = a; divisor = b;
        tick();
        start_valid = 1'b0; dividend = 16'hDEAD; divisor = 16'h0000;
        l = 1;
        while (!result_valid && l < 64) begin tick(); l++; end
    endtask

    task automatic consume();
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
    endtask

    task automatic check_res(input string tag, input logic [15:0] q, input logic [15:0] r,
                             input logic z, input logic o, input int lexp);
        chk({tag, ".lat"}, lat, lexp);
        chk({tag, ".q"}, quotient, q);
        chk({tag, ".r"}, remainder, r);
        chk({tag, ".dbz"}, divide_by_zero, z);
        chk({tag, ".ovf"}, overflow, o);
    endtask

    initial begin
        int seen;
        logic [15:0] q_hold;
        rst_n = 1'b0; start_valid = 1'b0; result_ready = 1'b0; dividend = '0; divisor = '0;
        repeat (2) tick();
        chk("rst.result_valid", result_valid, 0);
        chk("rst.q", quotient, 0);
        chk("rst.r", remainder, 0);
        chk("rst.dbz", divide_by_zero, 0);
        chk("rst.ovf", overflow, 0);
        rst_n = 1'b1;
        tick();
        chk("rst.start_ready", start_ready, 1);

        do_op(16'd100, 16'd7, lat);   check_res("100/7", 16'd14, 16'd2, 0, 0, 17);      consume();
        do_op(16'hFFFF, 16'd1, lat);  check_res("ffff/1", 16'hFFFF, 16'd0, 0, 0, 17);   consume();
`ifdef INTEGER_DIVIDER_SIGNED_EN
        do_op(16'd3, 16'hFFFF, lat);  check_res("3/ffff", 16'hFFFD, 16'd0, 0, 0, 17);   consume();
`else
        do_op(16'd3, 16'hFFFF, lat);  check_res("3/ffff", 16'd0, 16'd3, 0, 0, 17);      consume();
`endif
        do_op(16'd0, 16'd5, lat);     check_res("0/5", 16'd0, 16'd0, 0, 0, 17);         consume();
        do_op(16'd5, 16'd0, lat);     check_res("5/0", 16'hFFFF, 16'd5, 1, 0, 1);       consume();

        // Backpressure: result must hold for 5 cycles with start_ready low
        do_op(16'd1000, 16'd10, lat); check_res("1000/10", 16'd100, 16'd0, 0, 0, 17);
        q_hold = quotient;
        repeat (5) begin
            tick();
            chk("bp.valid", result_valid, 1);
            chk("bp.q_stable", quotient, q_hold);
            chk("bp.start_ready", start_ready, 0);
        end
        consume();
        chk("b2b.start_ready", start_ready, 1);
        do_op(16'd30000, 16'd301, lat); check_res("30000/301", 16'd99, 16'd201, 0, 0, 17);
        consume();

        // Reset at cycle 8 of 200/3, while the previous result still sits in the output registers
        start_valid = 1'b1; dividend = 16'd200; divisor = 16'd3;
        tick();
        start_valid = 1'b0;
        repeat (7) tick();
        chk("midrst.busy", start_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst.start_ready", start_ready, 1);
        chk("midrst.valid", result_valid, 0);
        chk("midrst.q", quotient, 0);
        chk("midrst.r", remainder, 0);
        #3 rst_n = 1'b1;
        seen = 0;
        repeat (20) begin tick(); if (result_valid) seen++; end
        chk("midrst.no_result", seen, 0);
        do_op(16'd200, 16'd3, lat);   check_res("200/3", 16'd66, 16'd2, 0, 0, 17);      consume();

`ifdef INTEGER_DIVIDER_SIGNED_EN
        do_op(16'hFFF9, 16'd2, lat);  check_res("s.-7/2", 16'hFFFD, 16'hFFFF, 0, 0, 17); consume();
        do_op(16'd7, 16'hFFFE, lat);  check_res("s.7/-2", 16'hFFFD, 16'd1, 0, 0, 17);    consume();
        do_op(16'h8000, 16'hFFFF, lat); check_res("s.min/-1", 16'h8000, 16'd0, 0, 1, 17); consume();
        do_op(16'hFFFB, 16'd0, lat);  check_res("s.-5/0", 16'd1, 16'hFFFB, 1, 0, 1);     consume();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
